// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register-file writeback arbiter.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned NREGS      = 2 ** ADDR_W_DEF;
    localparam int unsigned ZERO_REG   = 0;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  gnt
);

    logic found;

    // Two passes: first ptr..NREQ-1, then wrap to 0..ptr-1.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        if (en) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i >= int'(ptr))) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i]) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter with a one-entry write stage and pending-write scoreboard.
// Optional decode bypass outputs are enabled by defining RF_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic                   wr_stall,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic [2**ADDR_W-1:0]   pending,
    input  logic [ADDR_W-1:0]      rd_addr1,
    input  logic [ADDR_W-1:0]      rd_addr2,
    output logic                   byp_hit1,
    output logic                   byp_hit2,
    output logic [DATA_W-1:0]      byp_data1,
    output logic [DATA_W-1:0]      byp_data2
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR    = 2 ** ADDR_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stage_t;

    stage_t            stage_q, stage_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NR-1:0]     pending_q, pending_d;
    logic              retire, can_accept, accept, load;
    logic [NREQ-1:0]   gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign retire     = stage_q.valid & ~wr_stall;
    assign can_accept = ~stage_q.valid | retire;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  (can_accept),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx  = PTR_W'(i);
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Writes to the hard-zero register handshake but never occupy the stage.
    assign load = accept & (sel_addr != ADDR_W'(ZERO_REG));

    always_comb begin
        stage_d   = stage_q;
        pending_d = pending_q;
        rr_ptr_d  = rr_ptr_q;
        if (retire) begin
            stage_d.valid             = 1'b0;
            pending_d[stage_q.addr]   = 1'b0;
        end
        if (load) begin
            stage_d.valid       = 1'b1;
            stage_d.addr        = sel_addr;
            stage_d.data        = sel_data;
            pending_d[sel_addr] = 1'b1;
        end
        if (accept) begin
            rr_ptr_d = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_q   <= '0;
            pending_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            stage_q   <= stage_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign wr_en   = retire;
    assign wr_addr = stage_q.addr;
    assign wr_data = stage_q.data;
    assign pending = pending_q;

`ifdef RF_BYPASS_EN
    assign byp_hit1  = stage_q.valid & (stage_q.addr == rd_addr1) &
                       (rd_addr1 != ADDR_W'(ZERO_REG));
    assign byp_hit2  = stage_q.valid & (stage_q.addr == rd_addr2) &
                       (rd_addr2 != ADDR_W'(ZERO_REG));
    assign byp_data1 = stage_q.data;
    assign byp_data2 = stage_q.data;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_addr1, rd_addr2};
    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data1 = '0;
    assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued by the stimulus,
// a negedge monitor pops and compares them whenever wr_en is high.
module tb_regfile_wb_arbiter;

    localparam int NREQ   = 3;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   wr_stall;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic [2**ADDR_W-1:0]   pending;
    logic [ADDR_W-1:0]      rd_addr1, rd_addr2;
    logic                   byp_hit1, byp_hit2;
    logic [DATA_W-1:0]      byp_data1, byp_data2;

    regfile_wb_arbiter #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .wr_stall  (wr_stall),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pending   (pending),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        wr_stall  = 1'b0;
        #2;
        reset     = 1'b0;
    endtask

    // Monitor: every retired write must match the head of the expected queue.
    always @(negedge clock) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got addr %0h data %0h expected no write",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                chk("wr_data", 64'(wr_data), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [DATA_W-1:0] t2_data [3];
    logic [2:0]        oh;
    int                g;

    initial begin
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        wr_stall  = 1'b0;
        rd_addr1  = '0;
        rd_addr2  = '0;
        t2_data[0] = 16'h1111;
        t2_data[1] = 16'h2222;
        t2_data[2] = 16'h3333;

        // Reset state
        sample();
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_byp_hit1", 64'(byp_hit1), 64'd0);
        next_cycle();
        reset = 1'b0;

        // 1: single write to r5
        req_valid = 3'b001;
        set_req(0, 4'd5, 16'hBEEF);
        expect_wr(4'd5, 16'hBEEF);
        sample();
        chk("t1_ready", 64'(req_ready), 64'b001);
        chk("t1_pending_pre", 64'(pending), 64'd0);
        next_cycle();
        req_valid = '0;
        sample();
        chk("t1_wr_en", 64'(wr_en), 64'd1);
        chk("t1_pending5", 64'(pending), 64'h0020);
        next_cycle();
        sample();
        chk("t1_wr_en_off", 64'(wr_en), 64'd0);
        chk("t1_pending_clr", 64'(pending), 64'd0);

        // 2: all three requesting for six cycles -> 0,1,2,0,1,2
        next_cycle();
        do_reset();
        set_req(0, 4'd1, t2_data[0]);
        set_req(1, 4'd2, t2_data[1]);
        set_req(2, 4'd3, t2_data[2]);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            g  = k % 3;
            oh = 3'b001 << g;
            expect_wr(ADDR_W'(g + 1), t2_data[g]);
            sample();
            chk("t2_ready", 64'(req_ready), 64'(oh));
            if (k > 0) begin
                chk("t2_wr_en", 64'(wr_en), 64'd1);
                chk("t2_pending", 64'(pending), 64'd1 << (((k - 1) % 3) + 1));
            end
            next_cycle();
        end
        req_valid = '0;
        sample();
        chk("t2_wr_en_last", 64'(wr_en), 64'd1);
        next_cycle();
        sample();
        chk("t2_idle", 64'(wr_en), 64'd0);
        chk("t2_pending_clr", 64'(pending), 64'd0);

        // 3: stall with r3 in the stage
        next_cycle();
        do_reset();
        req_valid = 3'b010;
        set_req(1, 4'd3, 16'h0333);
        expect_wr(4'd3, 16'h0333);
        sample();
        chk("t3_ready_load", 64'(req_ready), 64'b010);
        next_cycle();
        wr_stall  = 1'b1;
        req_valid = 3'b101;
        set_req(0, 4'd6, 16'h0666);
        set_req(2, 4'd9, 16'h0999);
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("t3_stall_wr_en", 64'(wr_en), 64'd0);
            chk("t3_stall_ready", 64'(req_ready), 64'd0);
            chk("t3_stall_addr", 64'(wr_addr), 64'd3);
            chk("t3_stall_data", 64'(wr_data), 64'h0333);
            chk("t3_stall_pending", 64'(pending), 64'h0008);
            next_cycle();
        end
        wr_stall = 1'b0;
        expect_wr(4'd9, 16'h0999);
        sample();
        chk("t3_release_wr_en", 64'(wr_en), 64'd1);
        chk("t3_release_ready", 64'(req_ready), 64'b100);
        next_cycle();
        req_valid = 3'b001;
        expect_wr(4'd6, 16'h0666);
        sample();
        chk("t3_wrap_ready", 64'(req_ready), 64'b001);
        chk("t3_pending9", 64'(pending), 64'h0200);
        next_cycle();
        req_valid = '0;
        sample();
        chk("t3_pending6", 64'(pending), 64'h0040);
        next_cycle();
        sample();
        chk("t3_pending_clr", 64'(pending), 64'd0);

        // 4: write to hard-zero register
        next_cycle();
        do_reset();
        req_valid = 3'b001;
        set_req(0, 4'd0, 16'hFFFF);
        sample();
        chk("t4_ready", 64'(req_ready), 64'b001);
        next_cycle();
        req_valid = '0;
        sample();
        chk("t4_wr_en", 64'(wr_en), 64'd0);
        chk("t4_pending", 64'(pending), 64'd0);

        // 5: back-to-back writes to r7
        next_cycle();
        do_reset();
        req_valid = 3'b001;
        set_req(0, 4'd7, 16'h0007);
        expect_wr(4'd7, 16'h0007);
        sample();
        chk("t5_ready_a", 64'(req_ready), 64'b001);
        next_cycle();
        set_req(0, 4'd7, 16'h0077);
        expect_wr(4'd7, 16'h0077);
        sample();
        chk("t5_ready_b", 64'(req_ready), 64'b001);
        chk("t5_pending_a", 64'(pending), 64'h0080);
        next_cycle();
        req_valid = '0;
        sample();
        chk("t5_wr_en_b", 64'(wr_en), 64'd1);
        chk("t5_pending_b", 64'(pending), 64'h0080);
        next_cycle();
        sample();
        chk("t5_pending_clr", 64'(pending), 64'd0);

        // 6: bypass view of a stalled r4, then async reset mid-stall
        next_cycle();
        do_reset();
        req_valid = 3'b100;
        set_req(2, 4'd4, 16'h1234);
        expect_wr(4'd4, 16'h1234);
        sample();
        chk("t6_ready", 64'(req_ready), 64'b100);
        next_cycle();
        req_valid = '0;
        wr_stall  = 1'b1;
        rd_addr1  = 4'd4;
        rd_addr2  = 4'd0;
        sample();
        chk("t6_wr_en", 64'(wr_en), 64'd0);
        chk("t6_pending", 64'(pending), 64'h0010);
`ifdef RF_BYPASS_EN
        chk("t6_byp_hit1", 64'(byp_hit1), 64'd1);
        chk("t6_byp_data1", 64'(byp_data1), 64'h1234);
`else
        chk("t6_byp_hit1", 64'(byp_hit1), 64'd0);
        chk("t6_byp_data1", 64'(byp_data1), 64'd0);
`endif
        chk("t6_byp_hit2", 64'(byp_hit2), 64'd0);
        reset = 1'b1;
        #1;
        chk("t6_rst_wr_en", 64'(wr_en), 64'd0);
        chk("t6_rst_pending", 64'(pending), 64'd0);
        chk("t6_rst_byp_hit1", 64'(byp_hit1), 64'd0);
        exp_q.delete();
        #1;
        reset    = 1'b0;
        wr_stall = 1'b0;

        next_cycle();
        sample();
        chk("end_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
